// File: rtl/morph_frame_ctrl.sv
// Frame-level controller for an erosion/dilation pipeline: latches the morphology
// mode at frame start, measures input geometry and waits for the pipeline to drain.
module morph_frame_ctrl #(
  parameter int EXP_W     = 640,
  parameter int EXP_H     = 480,
  parameter int DRAIN_MAX = 4096,
  parameter int CNT_W     = 12
) (
  input  logic             pixelclk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_mode,
  input  logic             err_clr,
  input  logic             i_vs,
  input  logic             i_hs,
  input  logic             i_de,
  input  logic             p_vs,
  output logic             ero_en,
  output logic             dil_en,
  output logic             order,
  output logic             busy,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] o_width,
  output logic [CNT_W-1:0] o_height,
  output logic             err_geom,
  output logic             err_timeout
);

  localparam int               DW      = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_WC  = CNT_W'(EXP_W);
  localparam logic [CNT_W-1:0] EXP_HC  = CNT_W'(EXP_H);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // state is the observable FSM register for checkers and debug probes.
  state_t state;
  state_t state_nxt;

  logic             vs_q, pvs_q, hs_q;
  logic             vs_rise, vs_fall, pvs_fall, hs_fall;
  logic [2:0]       pend_mode, act_mode;
  logic [CNT_W-1:0] pix_cnt, line_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             go_run, end_run, frame_done, drain_tmo;
  logic             cfg_legal;

  // cfg_valid is a fire-and-forget strobe with no ready: every asserted cycle is
  // one write, accepted into pending if legal, otherwise answered by cfg_err.
  assign cfg_legal = (cfg_mode <= 3'd4);

  assign vs_rise  = i_vs & ~vs_q;
  assign vs_fall  = ~i_vs & vs_q;
  assign pvs_fall = ~p_vs & pvs_q;
  assign hs_fall  = ~i_hs & hs_q;

  always_comb begin
    state_nxt  = state;
    go_run     = 1'b0;
    end_run    = 1'b0;
    frame_done = 1'b0;
    drain_tmo  = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = ARM;
      ARM: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (vs_rise) begin
          go_run    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (vs_fall) begin
          end_run   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pvs_fall) begin
          frame_done = 1'b1;
          state_nxt  = en ? ARM : IDLE;
        end else if (drain_cnt == DRAIN_LAST) begin
          drain_tmo = 1'b1;
          state_nxt = en ? ARM : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    {ero_en, dil_en, order} = 3'b000;
    case (act_mode)
      3'd1:    {ero_en, dil_en, order} = 3'b100;
      3'd2:    {ero_en, dil_en, order} = 3'b010;
      3'd3:    {ero_en, dil_en, order} = 3'b110;
      3'd4:    {ero_en, dil_en, order} = 3'b111;
      default: {ero_en, dil_en, order} = 3'b000;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (rst) begin
      state       <= IDLE;
      vs_q        <= 1'b0;
      pvs_q       <= 1'b0;
      hs_q        <= 1'b0;
      pend_mode   <= 3'd0;
      act_mode    <= 3'd0;
      busy        <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
      frame_cnt   <= 16'd0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      drain_cnt   <= '0;
      o_width     <= '0;
      o_height    <= '0;
      err_geom    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      vs_q    <= i_vs;
      pvs_q   <= p_vs;
      hs_q    <= i_hs;
      busy    <= (state_nxt == RUN) || (state_nxt == DRAIN);
      cfg_ack <= go_run && (pend_mode != act_mode);
      cfg_err <= cfg_valid && !cfg_legal;

      // A write landing on the frame-start edge goes to pending only, so the
      // frame starting now still uses the previously pending mode.
      if (go_run) act_mode <= pend_mode;
      if (cfg_valid && cfg_legal) pend_mode <= cfg_mode;

      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;

      if (frame_done) frame_cnt <= frame_cnt + 16'd1;

      if (end_run) begin
        o_height <= line_cnt;
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else if (state == RUN) begin
        if (hs_fall && (pix_cnt != '0)) begin
          o_width <= pix_cnt;
          pix_cnt <= '0;
          if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 1'b1;
        end else if (i_de && (pix_cnt != CNT_MAX)) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end

      if (end_run && ((o_width != EXP_WC) || (line_cnt != EXP_HC))) err_geom <= 1'b1;
      else if (err_clr)                                          err_geom <= 1'b0;

      if (drain_tmo)    err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Bench for morph_frame_ctrl: directed frame scenarios plus randomized frames,
// checked against a frame-level model of modes, geometry, counts and errors.
module tb_morph_frame_ctrl;

  localparam int EXP_W     = 40;
  localparam int EXP_H     = 30;
  localparam int DRAIN_MAX = 4096;
  localparam int CNT_W     = 12;

  logic             pixelclk = 1'b0;
  logic             rst, en, cfg_valid, err_clr, i_vs, i_hs, i_de, p_vs;
  logic [2:0]       cfg_mode;
  logic             ero_en, dil_en, order, busy, cfg_ack, cfg_err, err_geom, err_timeout;
  logic [15:0]      frame_cnt;
  logic [CNT_W-1:0] o_width, o_height;

  morph_frame_ctrl #(
    .EXP_W(EXP_W), .EXP_H(EXP_H), .DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)
  ) dut (
    .pixelclk(pixelclk), .rst(rst), .en(en), .cfg_valid(cfg_valid),
    .cfg_mode(cfg_mode), .err_clr(err_clr), .i_vs(i_vs), .i_hs(i_hs),
    .i_de(i_de), .p_vs(p_vs), .ero_en(ero_en), .dil_en(dil_en), .order(order),
    .busy(busy), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .frame_cnt(frame_cnt),
    .o_width(o_width), .o_height(o_height), .err_geom(err_geom),
    .err_timeout(err_timeout)
  );

  // clock
  always #5 pixelclk = ~pixelclk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  // frame-level reference model
  int         m_pend, m_act, m_fc;
  bit         m_geom, m_tmo;
  logic [2:0] mode_tab [0:4];

  task automatic step();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int mode);
    cfg_valid = 1'b1;
    cfg_mode  = 3'(mode);
    step();
    cfg_valid = 1'b0;
    check_eq("cfg_err", 32'(cfg_err), 32'(mode > 4));
    if (mode <= 4) m_pend = mode;
    step();
    check_eq("cfg_err_pulse", 32'(cfg_err), 32'd0);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_geom = 1'b0;
    m_tmo  = 1'b0;
    check_eq("geom_clr", 32'(err_geom), 32'd0);
    check_eq("tmo_clr", 32'(err_timeout), 32'd0);
  endtask

  // One frame: vs rise, h lines of w pixels, vs fall, then pipeline vs fall
  // (or none when pvs_low, forcing the drain timeout).
  task automatic send_frame(input int w, input int h, input int coinc_mode,
                            input bit pvs_low, input int drop_line, input bit clr_at_fall);
    int         exp_ack, wsat, d;
    bit         geom_bad;
    logic [2:0] exp_en;
    exp_ack = (m_pend != m_act) ? 1 : 0;
    m_act   = m_pend;
    if (coinc_mode >= 0 && coinc_mode <= 4) m_pend = coinc_mode;
    exp_en   = mode_tab[m_act];
    wsat     = (w > 4095) ? 4095 : w;
    geom_bad = (wsat != EXP_W) || (h != EXP_H);
    m_geom   = geom_bad ? 1'b1 : (clr_at_fall ? 1'b0 : m_geom);
    exp_q.push_back(32'(wsat));
    exp_q.push_back(32'(h));
    exp_q.push_back(32'(m_geom));

    i_vs = 1'b1;
    if (coinc_mode >= 0) begin
      cfg_valid = 1'b1;
      cfg_mode  = 3'(coinc_mode);
    end
    step();
    cfg_valid = 1'b0;
    check_eq("cfg_ack", 32'(cfg_ack), 32'(exp_ack));
    check_eq("enables", 32'({ero_en, dil_en, order}), 32'(exp_en));
    check_eq("busy_run", 32'(busy), 32'd1);
    step();
    check_eq("cfg_ack_pulse", 32'(cfg_ack), 32'd0);
    p_vs = !pvs_low;
    step();
    step();
    for (int l = 0; l < h; l++) begin
      if (l == drop_line) en = 1'b0;
      i_hs = 1'b1;
      i_de = 1'b1;
      repeat (w) step();
      i_hs = 1'b0;
      i_de = 1'b0;
      repeat (3) step();
    end
    i_vs    = 1'b0;
    err_clr = clr_at_fall;
    step();
    err_clr = 1'b0;
    check_eq("o_width", 32'(o_width), exp_q.pop_front());
    check_eq("o_height", 32'(o_height), exp_q.pop_front());
    check_eq("err_geom", 32'(err_geom), exp_q.pop_front());
    check_eq("busy_drain", 32'(busy), 32'd1);
    if (!pvs_low) begin
      d = $urandom_range(1, 8);
      repeat (d - 1) step();
      p_vs = 1'b0;
      step();
      m_fc++;
    end else begin
      repeat (DRAIN_MAX - 1) step();
      check_eq("tmo_early", 32'(err_timeout), 32'(m_tmo));
      check_eq("busy_tmo_early", 32'(busy), 32'd1);
      step();
      m_tmo = 1'b1;
    end
    check_eq("frame_cnt", 32'(frame_cnt), 32'(m_fc[15:0]));
    check_eq("err_timeout", 32'(err_timeout), 32'(m_tmo));
    check_eq("busy_done", 32'(busy), 32'd0);
    step();
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, 32'({ero_en, dil_en, order, busy, cfg_ack, cfg_err,
                                   err_geom, err_timeout}), 32'd0);
    check_eq({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    check_eq({tag, "_geom"}, 32'({o_width, o_height}), 32'd0);
    check_eq({tag, "_state"}, 32'(dut.state), 32'd0);
  endtask

  initial begin
    int w, h, mode;
    mode_tab[0] = 3'b000;
    mode_tab[1] = 3'b100;
    mode_tab[2] = 3'b010;
    mode_tab[3] = 3'b110;
    mode_tab[4] = 3'b111;
    m_pend = 0; m_act = 0; m_fc = 0; m_geom = 1'b0; m_tmo = 1'b0;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_mode = 3'd0; err_clr = 1'b0;
    i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0; p_vs = 1'b0;

    // reset state
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_eq("idle_hold", 32'(dut.state), 32'd0);
    en = 1'b1;
    repeat (3) step();

    // open mode, nominal geometry
    cfg_write(3);
    send_frame(EXP_W, EXP_H, -1, 1'b0, -1, 1'b0);

    // illegal mode keeps previous enables, no ack
    cfg_write(6);
    send_frame(EXP_W, EXP_H, -1, 1'b0, -1, 1'b0);

    // coincident write deferred by one frame
    cfg_write(1);
    send_frame(EXP_W, EXP_H, 4, 1'b0, -1, 1'b0);
    send_frame(EXP_W, EXP_H, -1, 1'b0, -1, 1'b0);

    // short line -> geometry error; held p_vs -> drain timeout
    send_frame(EXP_W - 1, EXP_H, -1, 1'b0, -1, 1'b0);
    send_frame(EXP_W, EXP_H, -1, 1'b1, -1, 1'b0);
    clear_errs();

    // width saturation, error set beating a same-cycle clear
    send_frame(4200, 2, -1, 1'b0, -1, 1'b1);
    clear_errs();

    // randomized frames
    for (int r = 0; r < 6; r++) begin
      mode = $urandom_range(0, 7);
      cfg_write(mode);
      if ($urandom_range(0, 1) == 1) clear_errs();
      w = ($urandom_range(0, 1) == 1) ? EXP_W : $urandom_range(1, 50);
      h = ($urandom_range(0, 1) == 1) ? EXP_H : $urandom_range(1, 35);
      send_frame(w, h, -1, 1'b0, -1, 1'b0);
    end

    // en drop mid-RUN: frame completes, then IDLE ignores vsync
    send_frame(EXP_W, EXP_H, -1, 1'b0, EXP_H / 2, 1'b0);
    check_eq("drop_state", 32'(dut.state), 32'd0);
    check_eq("drop_busy", 32'(busy), 32'd0);
    i_vs = 1'b1;
    repeat (3) step();
    check_eq("idle_no_run", 32'(busy), 32'd0);
    i_vs = 1'b0;
    step();

    // reset mid-RUN, then re-entry only on a fresh vsync rise
    en = 1'b1;
    step();
    step();
    cfg_write(2);
    i_vs = 1'b1;
    step();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    i_hs = 1'b1;
    i_de = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_hs = 1'b0;
    i_de = 1'b0;
    check_all_zero("mid_rst");
    repeat (4) step();
    check_eq("no_stale_rise", 32'(busy), 32'd0);
    i_vs = 1'b0;
    repeat (2) step();
    i_vs = 1'b1;
    step();
    check_eq("fresh_rise_busy", 32'(busy), 32'd1);
    check_eq("fresh_rise_en", 32'({ero_en, dil_en, order, cfg_ack}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
